// File: rtl/ks_disp_pkg.sv
// rtl/ks_disp_pkg.sv - shared types and constants for the keystream display buffer
//
// Contents:
//   WORD_W          width of one displayed word (four hex digits)
//   DBNC_CYCLES_DEF default debounce length (10 ms at 50 MHz)
//   ks_state_e      capture/browse controller states
package ks_disp_pkg;

  localparam int WORD_W          = 16;
  localparam int DBNC_CYCLES_DEF = 500000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    BROWSE  = 2'd2
  } ks_state_e;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchroniser and debouncer with rising-edge pulse
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   din   in   raw asynchronous button level
//   dout  out  debounced level
//   rise  out  one-cycle pulse when dout goes 0 -> 1
module btn_debounce
  import ks_disp_pkg::*;
#(
  parameter int DBNC_CYCLES = DBNC_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int                CNT_W    = $clog2(DBNC_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DBNC_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      rise  <= 1'b0;
      // The count only survives while the synchronised level keeps
      // disagreeing with the output; any bounce back restarts it.
      if (sync2 != dout) begin
        if (cnt == CNT_LAST) begin
          dout <= sync2;
          rise <= sync2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ks_show_buffer.sv
// rtl/ks_show_buffer.sv - captures keystream bits into 16-bit words and browses them for the 7-seg driver
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start               level; begins a capture run from IDLE or BROWSE
//   ks_valid, ks_bit    serial keystream from the cipher core
//   ks_ready            high while capturing; a bit moves when ks_valid && ks_ready
//   btn_next, btn_prev  raw push-buttons stepping through stored words
//   show                word on the seven-segment display
//   word_idx            index of the word on show
//   done                capture complete, browse mode active
module ks_show_buffer
  import ks_disp_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int DBNC_CYCLES = DBNC_CYCLES_DEF,
  parameter int IDX_W       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ks_valid,
  input  logic              ks_bit,
  output logic              ks_ready,
  input  logic              btn_next,
  input  logic              btn_prev,
  output logic [WORD_W-1:0] show,
  output logic [IDX_W-1:0]  word_idx,
  output logic              done
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DEPTH - 1);

  ks_state_e         state;
  ks_state_e         state_nxt;
  logic [WORD_W-2:0] shift;      // the 15 most recent bits; the 16th arrives with ks_bit
  logic [3:0]        bitcnt;
  logic [IDX_W-1:0]  wr_ptr;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] mem [DEPTH];

  logic              accept;
  logic              word_done;
  logic              last_word;
  logic [WORD_W-1:0] word_in;
  logic              next_pulse;
  logic              prev_pulse;
  logic              next_lvl;
  logic              prev_lvl;
  logic              unused_lvl;

  btn_debounce #(.DBNC_CYCLES(DBNC_CYCLES)) u_dbnc_next (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_next),
    .dout (next_lvl),
    .rise (next_pulse)
  );

  btn_debounce #(.DBNC_CYCLES(DBNC_CYCLES)) u_dbnc_prev (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_prev),
    .dout (prev_lvl),
    .rise (prev_pulse)
  );

  // Only the edge pulses matter here; the levels are kept for observability.
  assign unused_lvl = next_lvl ^ prev_lvl;

  assign ks_ready  = (state == CAPTURE);
  assign done      = (state == BROWSE);
  assign accept    = ks_valid && ks_ready;
  assign word_in   = {shift, ks_bit};
  assign word_done = accept && (bitcnt == 4'd15);
  assign last_word = word_done && (wr_ptr == IDX_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = CAPTURE;
      CAPTURE: if (last_word) state_nxt = BROWSE;
      BROWSE:  if (start)     state_nxt = CAPTURE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Distributed RAM: no reset, entries are always rewritten before being shown.
  always_ff @(posedge clk) begin
    if (word_done) begin
      mem[wr_ptr] <= word_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift    <= '0;
      bitcnt   <= '0;
      wr_ptr   <= '0;
      idx      <= '0;
      show     <= '0;
      word_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift  <= '0;
            bitcnt <= '0;
            wr_ptr <= '0;
            idx    <= '0;
          end
        end
        CAPTURE: begin
          if (accept) begin
            shift  <= word_in[WORD_W-2:0];
            bitcnt <= bitcnt + 4'd1;
          end
          if (word_done) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (last_word) begin
              // mem[0] was written by an earlier word of this run.
              show     <= mem[0];
              word_idx <= '0;
              idx      <= '0;
            end else begin
              show     <= word_in;
              word_idx <= wr_ptr;
            end
          end
        end
        BROWSE: begin
          if (start) begin
            shift  <= '0;
            bitcnt <= '0;
            wr_ptr <= '0;
            idx    <= '0;
          end else begin
            if (next_pulse && !prev_pulse) begin
              idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end else if (prev_pulse && !next_pulse) begin
              idx <= (idx == '0) ? IDX_MAX : idx - 1'b1;
            end
            // Display follows idx one cycle later.
            show     <= mem[idx];
            word_idx <= idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ks_show_buffer.sv
// tb/tb_ks_show_buffer.sv - self-checking bench for ks_show_buffer
module tb_ks_show_buffer;

  localparam int DEPTH = 4;
  localparam int DBNC  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ks_valid;
  logic        ks_bit;
  logic        ks_ready;
  logic        btn_next;
  logic        btn_prev;
  logic [15:0] show;
  logic [1:0]  word_idx;
  logic        done;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] words [DEPTH];
  int          midx;

  always #5 clk = ~clk;

  ks_show_buffer #(.DEPTH(DEPTH), .DBNC_CYCLES(DBNC)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ks_valid (ks_valid),
    .ks_bit   (ks_bit),
    .ks_ready (ks_ready),
    .btn_next (btn_next),
    .btn_prev (btn_prev),
    .show     (show),
    .word_idx (word_idx),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_show"}, show, 32'h0);
    chk({tag, "_idx"}, word_idx, 32'h0);
    chk({tag, "_done"}, done, 32'h0);
    chk({tag, "_ready"}, ks_ready, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Captures four words; mode 0: ks_valid low every third cycle,
  // mode 1: random gaps and random start pulses (start must be ignored).
  task automatic capture(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d, input int mode);
    int          n = 0;
    int          cyc = 0;
    logic        v;
    logic [15:0] w;
    words[0] = a; words[1] = b; words[2] = c; words[3] = d;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    while (n < 16 * DEPTH && cyc < 1000) begin
      chk("ready_in_capture", ks_ready, 32'h1);
      v        = (mode == 0) ? (cyc % 3 != 2) : ($urandom_range(0, 3) != 0);
      w        = words[n / 16];
      ks_valid = v;
      ks_bit   = w[15 - (n % 16)];
      if (mode != 0) start = ($urandom_range(0, 7) == 0);
      @(posedge clk);
      if (v) n++;
      cyc++;
      @(negedge clk);
      ks_valid = 1'b0;
      start    = 1'b0;
      if (v && (n % 16 == 0) && n < 16 * DEPTH) begin
        chk("live_show", show, words[n / 16 - 1]);
        chk("live_idx", word_idx, n / 16 - 1);
        chk("live_done", done, 32'h0);
      end
    end
    if (cyc >= 1000) chk("capture_timeout", 32'h0, 32'h1);
    chk("end_done", done, 32'h1);
    chk("end_ready", ks_ready, 32'h0);
    chk("end_show", show, words[0]);
    chk("end_idx", word_idx, 32'h0);
    midx = 0;
  endtask

  task automatic press(input logic nx, input logic pv, input int hold, input logic chk_lat);
    int old = midx;
    int lat = -1;
    if (nx && !pv)      midx = (midx + 1) % DEPTH;
    else if (pv && !nx) midx = (midx + DEPTH - 1) % DEPTH;
    @(negedge clk);
    btn_next = nx;
    btn_prev = pv;
    for (int c = 1; c <= hold; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (lat < 0 && int'(word_idx) != old) lat = c;
    end
    btn_next = 1'b0;
    btn_prev = 1'b0;
    repeat (DBNC + 8) @(negedge clk);
    chk("browse_idx", word_idx, midx);
    chk("browse_show", show, words[midx]);
    chk("browse_done", done, 32'h1);
    if (chk_lat) chk("press_latency_in_range", (lat >= DBNC && lat <= DBNC + 4), 32'h1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; ks_valid = 1'b0; ks_bit = 1'b0;
    btn_next = 1'b0; btn_prev = 1'b0;

    // 1: reset values, idle without start
    do_reset();
    check_reset_vals("reset");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", ks_ready, 32'h0);
      chk("idle_done", done, 32'h0);
    end

    // 2: directed capture with periodic gaps
    capture(16'hA5C3, 16'h1234, 16'hFFFF, 16'h0001, 0);

    // 3: four next presses with wrap
    press(1'b1, 1'b0, 10, 1'b1);
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 10, 1'b0);

    // 4: prev wraps backwards, both together do nothing
    press(1'b0, 1'b1, 10, 1'b1);
    press(1'b1, 1'b1, 10, 1'b0);

    // 5: bounce rejected, then one clean press
    @(negedge clk);
    btn_next = 1'b1; repeat (2) @(negedge clk);
    btn_next = 1'b0; repeat (3) @(negedge clk);
    btn_next = 1'b1; repeat (2) @(negedge clk);
    btn_next = 1'b0; repeat (DBNC + 8) @(negedge clk);
    chk("glitch_idx", word_idx, midx);
    chk("glitch_show", show, words[midx]);
    press(1'b1, 1'b0, 10, 1'b0);

    // Randomised run: random words, gaps, ignored starts, random presses
    capture(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1);
    for (int i = 0; i < 8; i++) begin
      press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10, 1'b0);
    end

    // 6: reset in the middle of a run, then a clean run
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ks_valid = 1'b1;
      ks_bit   = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    ks_valid = 1'b0;
    do_reset();
    check_reset_vals("midrun_reset");
    capture(16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F, 0);
    press(1'b1, 1'b0, 10, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
